// File: rtl/gpio_serial_loader.sv
// Purpose : fetches one pad-control word per GPIO from the config register file and shifts the words
//           serially into the daisy-chained pad-control registers, then pulses the chain load strobe.
// Latency : done is NUM_GPIO*(2+2*PAD_CTRL_BITS*CLK_DIV)+2*CLK_DIV cycles after start is sampled;
//           a chain reset takes 2*CLK_DIV cycles.
// Backpressure: none. start/chain_rst_req are accepted only while idle; requests made while busy are dropped.
// Ports:
//   wb_clk_i, wb_rst_i           clock, synchronous active-high reset
//   start, chain_rst_req         one-cycle requests (chain reset wins when both are asserted)
//   busy, done                   sequence status and one-cycle completion pulse
//   cfg_rd, cfg_addr, cfg_data   register-file read port (data returns the cycle after cfg_rd)
//   serial_clock, serial_load, serial_resetn, serial_data_out   pad-control chain interface
module gpio_serial_loader #(
    parameter int NUM_GPIO      = 38,
    parameter int PAD_CTRL_BITS = 10,
    parameter int ADDR_W        = 6,
    parameter int CLK_DIV       = 1
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     start,
    input  logic                     chain_rst_req,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_rd,
    output logic [ADDR_W-1:0]        cfg_addr,
    input  logic [PAD_CTRL_BITS-1:0] cfg_data,
    output logic                     serial_clock,
    output logic                     serial_load,
    output logic                     serial_resetn,
    output logic                     serial_data_out
);

    localparam int PTR_W = $clog2(PAD_CTRL_BITS);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;

    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_GPIO - 1);
    localparam logic [PTR_W-1:0]  PTR_MSB  = PTR_W'(PAD_CTRL_BITS - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_CRST = DIV_W'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD_HI,
        LOAD_LO,
        CRST
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        idx_q, idx_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [DIV_W-1:0]         div_q, div_d;
    logic [PAD_CTRL_BITS-1:0] word_q, word_d;

    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     cfg_rd_q, cfg_rd_d;
    logic [ADDR_W-1:0]        cfg_addr_q, cfg_addr_d;
    logic                     sclk_q, sclk_d;
    logic                     sload_q, sload_d;
    logic                     srstn_q, srstn_d;
    logic                     sdat_q, sdat_d;

    logic                     div_zero;

    assign div_zero = (div_q == '0);

    // Next-state logic. Each timed state loads div with its length minus one on entry
    // and leaves when div reaches zero.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        div_d   = div_q;
        word_d  = word_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (chain_rst_req) begin
                    state_d = CRST;
                    div_d   = DIV_CRST;
                end else if (start) begin
                    state_d = FETCH;
                    idx_d   = IDX_LAST;
                end
            end
            FETCH: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d = SHIFT_LO;
                word_d  = cfg_data;
                ptr_d   = PTR_MSB;
                div_d   = DIV_HALF;
            end
            SHIFT_LO: begin
                if (div_zero) begin
                    state_d = SHIFT_HI;
                    div_d   = DIV_HALF;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            SHIFT_HI: begin
                if (!div_zero) begin
                    div_d = div_q - 1'b1;
                end else if (ptr_q != '0) begin
                    state_d = SHIFT_LO;
                    ptr_d   = ptr_q - 1'b1;
                    div_d   = DIV_HALF;
                end else if (idx_q != '0) begin
                    state_d = FETCH;
                    idx_d   = idx_q - 1'b1;
                end else begin
                    state_d = LOAD_HI;
                    div_d   = DIV_HALF;
                end
            end
            LOAD_HI: begin
                if (div_zero) begin
                    state_d = LOAD_LO;
                    div_d   = DIV_HALF;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            LOAD_LO, CRST: begin
                if (div_zero) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with
    // the state they describe.
    always_comb begin
        busy_d     = (state_d != IDLE);
        cfg_rd_d   = (state_d == FETCH);
        cfg_addr_d = (state_d == FETCH) ? idx_d : cfg_addr_q;
        sclk_d     = (state_d == SHIFT_HI);
        sload_d    = (state_d == LOAD_HI);
        srstn_d    = (state_d != CRST);
        // Data moves only when entering/staying in SHIFT_LO, i.e. only while the clock is low.
        sdat_d     = (state_d == SHIFT_LO) ? word_d[ptr_d] : sdat_q;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ptr_q      <= '0;
            div_q      <= '0;
            word_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_rd_q   <= 1'b0;
            cfg_addr_q <= '0;
            sclk_q     <= 1'b0;
            sload_q    <= 1'b0;
            srstn_q    <= 1'b0;
            sdat_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            div_q      <= div_d;
            word_q     <= word_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_rd_q   <= cfg_rd_d;
            cfg_addr_q <= cfg_addr_d;
            sclk_q     <= sclk_d;
            sload_q    <= sload_d;
            srstn_q    <= srstn_d;
            sdat_q     <= sdat_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign cfg_rd          = cfg_rd_q;
    assign cfg_addr        = cfg_addr_q;
    assign serial_clock    = sclk_q;
    assign serial_load     = sload_q;
    assign serial_resetn   = srstn_q;
    assign serial_data_out = sdat_q;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Purpose : bench for gpio_serial_loader; three instances cover (N=2,P=10,D=1), (N=2,P=10,D=3), (N=1,P=2,D=1).
// Latency : expected done latencies are hand-computed per vector.
// Backpressure: none; a model register file answers cfg_rd one cycle later and a model chain captures serial bits.
module tb_gpio_serial_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] start_s = '0;
    logic [2:0] crst_s  = '0;
    logic [2:0] busy_s, done_s, rd_s, sclk_s, sload_s, rn_s, sdat_s;
    logic [5:0] addr_s [3];
    logic [9:0] cdat_s [3];
    logic [9:0] mem    [3][2];

    gpio_serial_loader #(.NUM_GPIO(2), .PAD_CTRL_BITS(10), .ADDR_W(6), .CLK_DIV(1)) u_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start_s[0]), .chain_rst_req(crst_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .cfg_rd(rd_s[0]), .cfg_addr(addr_s[0]),
        .cfg_data(cdat_s[0]), .serial_clock(sclk_s[0]), .serial_load(sload_s[0]),
        .serial_resetn(rn_s[0]), .serial_data_out(sdat_s[0]));

    gpio_serial_loader #(.NUM_GPIO(2), .PAD_CTRL_BITS(10), .ADDR_W(6), .CLK_DIV(3)) u_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start_s[1]), .chain_rst_req(crst_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .cfg_rd(rd_s[1]), .cfg_addr(addr_s[1]),
        .cfg_data(cdat_s[1]), .serial_clock(sclk_s[1]), .serial_load(sload_s[1]),
        .serial_resetn(rn_s[1]), .serial_data_out(sdat_s[1]));

    gpio_serial_loader #(.NUM_GPIO(1), .PAD_CTRL_BITS(2), .ADDR_W(6), .CLK_DIV(1)) u_c (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start_s[2]), .chain_rst_req(crst_s[2]),
        .busy(busy_s[2]), .done(done_s[2]), .cfg_rd(rd_s[2]), .cfg_addr(addr_s[2]),
        .cfg_data(cdat_s[2][1:0]), .serial_clock(sclk_s[2]), .serial_load(sload_s[2]),
        .serial_resetn(rn_s[2]), .serial_data_out(sdat_s[2]));

    // Model register file: read data appears the cycle after cfg_rd.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rd_s[i]) cdat_s[i] <= mem[i][addr_s[i][0]];
        end
    end

    // Monitor / model chain, sampled on the falling edge. Statistics restart when an
    // idle instance sees a request.
    int         divs [3] = '{1, 3, 1};
    int         edges[3], loads[3], dones[3], rds[3], rnlow[3], lvl_err[3], data_err[3];
    int         run[3], t0[3], done_cyc[3];
    logic [19:0] chain[3], latched[3];
    logic [11:0] aseq[3];
    logic [2:0]  fell = '0;
    logic [2:0]  psclk = '0, psload = '0, psdat = '0;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if ((start_s[i] || crst_s[i]) && !busy_s[i]) begin
                edges[i] <= 0; loads[i] <= 0; dones[i] <= 0; rds[i] <= 0; rnlow[i] <= 0;
                lvl_err[i] <= 0; data_err[i] <= 0; chain[i] <= '0; latched[i] <= '0;
                aseq[i] <= '0; fell[i] <= 1'b0; t0[i] <= cyc + 1; run[i] <= 1;
            end else begin
                if (sclk_s[i] && !psclk[i]) begin
                    edges[i] <= edges[i] + 1;
                    chain[i] <= {chain[i][18:0], sdat_s[i]};
                end
                if (sclk_s[i] != psclk[i]) begin
                    run[i] <= 1;
                    if (psclk[i] && run[i] != divs[i]) lvl_err[i] <= lvl_err[i] + 1;
                    if (!psclk[i] && fell[i] && run[i] != divs[i] && run[i] != divs[i] + 2)
                        lvl_err[i] <= lvl_err[i] + 1;
                    if (psclk[i]) fell[i] <= 1'b1;
                end else begin
                    run[i] <= run[i] + 1;
                end
                if (sclk_s[i] && sdat_s[i] != psdat[i]) data_err[i] <= data_err[i] + 1;
                if (sload_s[i] && !psload[i]) begin
                    loads[i]   <= loads[i] + 1;
                    latched[i] <= chain[i];
                end
                if (done_s[i]) begin
                    dones[i]    <= dones[i] + 1;
                    done_cyc[i] <= cyc;
                end
                if (rd_s[i]) begin
                    rds[i]  <= rds[i] + 1;
                    aseq[i] <= {aseq[i][5:0], addr_s[i]};
                end
                if (!rn_s[i]) rnlow[i] <= rnlow[i] + 1;
            end
            psclk[i]  <= sclk_s[i];
            psload[i] <= sload_s[i];
            psdat[i]  <= sdat_s[i];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic pulse_start(input int i);
        @(posedge clk); #1 start_s[i] = 1'b1;
        @(posedge clk); #1 start_s[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input string nm);
        for (int k = 0; k < 400 && dones[i] == 0; k++) @(negedge clk);
        if (dones[i] == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done, expected done within 400 cycles", nm);
        end
        repeat (6) @(negedge clk);
    endtask

    typedef struct {
        int          inst;
        logic [9:0]  c0;
        logic [9:0]  c1;
        int          lat;
        int          n_edges;
        int          n_rds;
        logic [11:0] addr_seq;
        logic [19:0] chain_val;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input int v);
        int i;
        string nm;
        i  = vecs[v].inst;
        nm = $sformatf("v%0d", v);
        mem[i][0] = vecs[v].c0;
        mem[i][1] = vecs[v].c1;
        pulse_start(i);
        wait_done(i, nm);
        chk({nm, "_latency"}, done_cyc[i] - t0[i], vecs[v].lat);
        chk({nm, "_edges"},   edges[i], vecs[v].n_edges);
        chk({nm, "_chain"},   chain[i], vecs[v].chain_val);
        chk({nm, "_latched"}, latched[i], vecs[v].chain_val);
        chk({nm, "_loads"},   loads[i], 1);
        chk({nm, "_dones"},   dones[i], 1);
        chk({nm, "_rds"},     rds[i], vecs[v].n_rds);
        chk({nm, "_addrs"},   aseq[i], vecs[v].addr_seq);
        chk({nm, "_levels"},  lvl_err[i], 0);
        chk({nm, "_stable"},  data_err[i], 0);
        chk({nm, "_idle"},    busy_s[i], 0);
    endtask

    initial begin
        vecs[0] = '{0, 10'h2A5, 10'h1C3, 46,  20, 2, 12'h040, {10'h1C3, 10'h2A5}};
        vecs[1] = '{0, 10'h000, 10'h3FF, 46,  20, 2, 12'h040, {10'h3FF, 10'h000}};
        vecs[2] = '{0, 10'h155, 10'h2AA, 46,  20, 2, 12'h040, {10'h2AA, 10'h155}};
        vecs[3] = '{1, 10'h2A5, 10'h1C3, 130, 20, 2, 12'h040, {10'h1C3, 10'h2A5}};
        vecs[4] = '{2, 10'h002, 10'h000, 8,   2,  1, 12'h000, 20'h00002};
        for (int i = 0; i < 3; i++) begin
            mem[i][0] = '0;
            mem[i][1] = '0;
        end

        // Reset values on all instances.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  busy_s,  3'b000);
        chk("rst_done",  done_s,  3'b000);
        chk("rst_rd",    rd_s,    3'b000);
        chk("rst_addr",  addr_s[0] | addr_s[1] | addr_s[2], 6'd0);
        chk("rst_sclk",  sclk_s,  3'b000);
        chk("rst_sload", sload_s, 3'b000);
        chk("rst_sdat",  sdat_s,  3'b000);
        chk("rst_rn",    rn_s,    3'b000);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_rn_release", rn_s, 3'b111);

        for (int v = 0; v < 5; v++) run_vec(v);

        // Extra starts while running are dropped.
        mem[0][0] = 10'h2A5;
        mem[0][1] = 10'h1C3;
        pulse_start(0);
        repeat (4) @(posedge clk);
        #1 start_s[0] = 1'b1;
        @(posedge clk); #1 start_s[0] = 1'b0;
        repeat (34) @(posedge clk);
        #1 start_s[0] = 1'b1;
        @(posedge clk); #1 start_s[0] = 1'b0;
        wait_done(0, "ign");
        chk("ign_dones",   dones[0], 1);
        chk("ign_edges",   edges[0], 20);
        chk("ign_latency", done_cyc[0] - t0[0], 46);
        chk("ign_chain",   latched[0], {10'h1C3, 10'h2A5});

        // Chain reset wins over a simultaneous start.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1 start_s[i] = 1'b1; crst_s[i] = 1'b1;
            @(posedge clk); #1 start_s[i] = 1'b0; crst_s[i] = 1'b0;
            wait_done(i, $sformatf("crst%0d", i));
            chk($sformatf("crst%0d_rnlow", i),   rnlow[i], 2 * divs[i]);
            chk($sformatf("crst%0d_latency", i), done_cyc[i] - t0[i], 2 * divs[i]);
            chk($sformatf("crst%0d_dones", i),   dones[i], 1);
            chk($sformatf("crst%0d_rds", i),     rds[i], 0);
            chk($sformatf("crst%0d_edges", i),   edges[i], 0);
        end

        // Reset in the middle of shifting aborts without done.
        pulse_start(0);
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_busy",  busy_s[0],  0);
        chk("abort_sclk",  sclk_s[0],  0);
        chk("abort_sload", sload_s[0], 0);
        chk("abort_rn",    rn_s[0],    0);
        repeat (60) @(negedge clk);
        chk("abort_dones", dones[0], 0);
        chk("abort_loads", loads[0], 0);
        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
